// File: rtl/asic_watch_pkg.sv
// Shared constants for the watch time base: crystal frequency and prescaler defaults.
package asic_watch_pkg;

  localparam int XTAL_HZ       = 32768;
  localparam int CNT_W_DEF     = 15;
  localparam int FAST_W_DEF    = 9;
  localparam int TRIM_W_DEF    = 8;
  localparam int CAL_TICKS_DEF = 60;

  // Counter width able to hold 0..ticks-1, never narrower than one bit.
  function automatic int cal_width(input int ticks);
    return (ticks > 2) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/crystal_prescaler_tc_counter.sv
// Terminal-count counter: counts enabled cycles, wraps to zero at term and
// flags the wrapping cycle; clear wins over everything and suppresses the wrap.
module tc_counter
  import asic_watch_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  logic [W-1:0] count_r;

  assign wrap  = en & ~clr & (count_r == term);
  assign count = count_r;

  // Count register: clear, wrap at terminal, or advance when enabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_r <= ZERO;
    end else if (clr) begin
      count_r <= ZERO;
    end else if (wrap) begin
      count_r <= ZERO;
    end else if (en) begin
      count_r <= count_r + ONE;
    end
  end

endmodule

// File: rtl/crystal_prescaler.sv
// Watch-crystal prescaler: 2**CNT_W period tick with periodic signed trim,
// fast time-setting mode, enable, synchronous restart and legacy square wave.
module crystal_prescaler
  import asic_watch_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int FAST_W    = FAST_W_DEF,
  parameter int TRIM_W    = TRIM_W_DEF,
  parameter int CAL_TICKS = CAL_TICKS_DEF
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              fast_i,
  input  logic [TRIM_W-1:0] trim_i,
  input  logic              trim_ld_i,
  output logic              tick_o,
  output logic              clk_o,
  output logic              cal_o
);

  localparam int CAL_W = cal_width(CAL_TICKS);
  localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CAL_TICKS - 1);
  localparam logic [CAL_W-1:0] CAL_PRE  = CAL_W'(CAL_TICKS - 2);
  // Terminal values live in CNT_W+1 bits so a positive trim cannot overflow.
  localparam logic [CNT_W:0] NOM_TERM  = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W:0] FAST_TERM = {{(CNT_W + 1 - FAST_W){1'b0}}, {FAST_W{1'b1}}};

  logic              mode_r;
  logic              tick_r;
  logic              clk_r;
  logic              cal_o_r;
  logic [TRIM_W-1:0] trim_sh_r;
  logic [TRIM_W-1:0] trim_act_r;

  logic              mode_chg_s;
  logic              main_clr_s;
  logic              tick_ev_s;
  logic              cal_adv_s;
  logic              cal_wrap_s;
  logic [CNT_W:0]    trim_ext_s;
  logic [CNT_W:0]    term_s;
  logic [CNT_W:0]    main_count_s;
  logic [CAL_W-1:0]  cal_count_s;
  logic              unused_s;

  assign mode_chg_s = fast_i ^ mode_r;
  assign main_clr_s = clr_i | mode_chg_s;
  assign cal_adv_s  = tick_ev_s & ~mode_r;
  assign trim_ext_s = {{(CNT_W + 1 - TRIM_W){trim_act_r[TRIM_W-1]}}, trim_act_r};
  assign unused_s   = ^main_count_s;

  // Terminal count selection for the period in progress.
  always_comb begin
    term_s = NOM_TERM;
    if (mode_r) begin
      term_s = FAST_TERM;
    end else if (cal_o_r) begin
      term_s = NOM_TERM + trim_ext_s;
    end else begin
      term_s = NOM_TERM;
    end
  end

  tc_counter #(
    .W (CNT_W + 1)
  ) u_main (
    .clk   (clk_i),
    .rstn  (rstn_i),
    .en    (en_i),
    .clr   (main_clr_s),
    .term  (term_s),
    .count (main_count_s),
    .wrap  (tick_ev_s)
  );

  tc_counter #(
    .W (CAL_W)
  ) u_cal (
    .clk   (clk_i),
    .rstn  (rstn_i),
    .en    (cal_adv_s),
    .clr   (clr_i),
    .term  (CAL_LAST),
    .count (cal_count_s),
    .wrap  (cal_wrap_s)
  );

  // Mode, tick and square-wave registers; active trim only moves on a tick.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mode_r     <= 1'b0;
      tick_r     <= 1'b0;
      clk_r      <= 1'b0;
      trim_act_r <= {TRIM_W{1'b0}};
    end else begin
      mode_r <= fast_i;
      tick_r <= tick_ev_s;
      if (tick_ev_s) begin
        clk_r      <= ~clk_r;
        trim_act_r <= trim_sh_r;
      end
    end
  end

  // Trim shadow register, loadable whether or not counting is enabled.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      trim_sh_r <= {TRIM_W{1'b0}};
    end else if (trim_ld_i) begin
      trim_sh_r <= trim_i;
    end
  end

  // cal_o tracks the cal counter's next value so it is high for its last state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cal_o_r <= 1'b0;
    end else if (clr_i) begin
      cal_o_r <= 1'b0;
    end else if (cal_adv_s) begin
      cal_o_r <= ~cal_wrap_s & (cal_count_s == CAL_PRE);
    end
  end

  assign tick_o = tick_r;
  assign clk_o  = clk_r;
  assign cal_o  = cal_o_r;

endmodule

// File: tb/tb_crystal_prescaler.sv
// Bench for crystal_prescaler: directed period checks plus random stimulus
// compared every cycle against a period-length reference model.
module tb_crystal_prescaler;

  localparam int CNT_W     = 4;
  localparam int FAST_W    = 2;
  localparam int TRIM_W    = 3;
  localparam int CAL_TICKS = 3;
  localparam int NOM       = 1 << CNT_W;
  localparam int FASTP     = 1 << FAST_W;

  logic              clk_i     = 1'b0;
  logic              rstn_i    = 1'b0;
  logic              en_i      = 1'b0;
  logic              clr_i     = 1'b0;
  logic              fast_i    = 1'b0;
  logic [TRIM_W-1:0] trim_i    = '0;
  logic              trim_ld_i = 1'b0;
  logic              tick_o;
  logic              clk_o;
  logic              cal_o;

  int n_vec = 0;
  int n_err = 0;

  // reference model: cycles elapsed in the current period and its length
  int m_el, m_cal, m_tsh, m_tact;
  bit m_fast, m_tick, m_clk;

  crystal_prescaler #(
    .CNT_W(CNT_W), .FAST_W(FAST_W), .TRIM_W(TRIM_W), .CAL_TICKS(CAL_TICKS)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .en_i(en_i), .clr_i(clr_i), .fast_i(fast_i),
    .trim_i(trim_i), .trim_ld_i(trim_ld_i),
    .tick_o(tick_o), .clk_o(clk_o), .cal_o(cal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic model_reset();
    m_el = 0; m_cal = 0; m_tsh = 0; m_tact = 0;
    m_fast = 0; m_tick = 0; m_clk = 0;
  endtask

  task automatic model_edge();
    int len;
    bit tk;
    if (!rstn_i) begin
      model_reset();
    end else begin
      len = m_fast ? FASTP : ((m_cal == CAL_TICKS - 1) ? NOM + m_tact : NOM);
      tk = 0;
      if (clr_i) begin
        m_el = 0; m_cal = 0;
      end else if (fast_i != m_fast) begin
        m_el = 0;
      end else if (!en_i) begin
        tk = 0;
      end else if (m_el + 1 == len) begin
        tk = 1; m_el = 0; m_clk = !m_clk;
        if (!m_fast) m_cal = (m_cal + 1) % CAL_TICKS;
      end else begin
        m_el++;
      end
      if (tk) m_tact = m_tsh;
      if (trim_ld_i) m_tsh = int'($signed(trim_i));
      m_fast = fast_i;
      m_tick = tk;
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    check_val("tick_o", {31'd0, tick_o}, {31'd0, m_tick});
    check_val("clk_o", {31'd0, clk_o}, {31'd0, m_clk});
    check_val("cal_o", {31'd0, cal_o}, (m_cal == CAL_TICKS - 1) ? 32'd1 : 32'd0);
  endtask

  // steps until a tick; trim_ld_i is a one-cycle pulse on the first step
  task automatic run_until_tick(input string tag, input int exp_len);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < 64) begin
      step();
      trim_ld_i = 1'b0;
      n++;
      if (tick_o === 1'b1) seen = 1;
    end
    check_val(tag, seen ? n : -1, exp_len);
  endtask

  initial begin
    model_reset();
    @(negedge clk_i);
    repeat (3) step();
    check_val("rst_tick", {31'd0, tick_o}, 32'd0);
    check_val("rst_clk", {31'd0, clk_o}, 32'd0);
    check_val("rst_cal", {31'd0, cal_o}, 32'd0);

    // nominal periods after reset release
    rstn_i = 1'b1; en_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_until_tick("t1_period", NOM);
      check_val("t1_clk", {31'd0, clk_o}, (k % 2 == 0) ? 32'd1 : 32'd0);
    end

    // positive then negative trim on the last period of each group
    trim_i = 3'b010; trim_ld_i = 1'b1;
    run_until_tick("t2_p1", 16);
    run_until_tick("t2_p2", 16);
    check_val("t2_cal_hi", {31'd0, cal_o}, 32'd1);
    run_until_tick("t2_p3", 18);
    trim_i = 3'b101; trim_ld_i = 1'b1;
    run_until_tick("t2_n1", 16);
    run_until_tick("t2_n2", 16);
    run_until_tick("t2_n3", 13);

    // fast mode entered mid-period at count 7, then left again
    repeat (7) step();
    fast_i = 1'b1;
    run_until_tick("t3_enter", 5);
    run_until_tick("t3_fast1", 4);
    run_until_tick("t3_fast2", 4);
    check_val("t3_cal_frozen", {31'd0, cal_o}, 32'd0);
    fast_i = 1'b0;
    run_until_tick("t3_exit", 17);

    // enable low for 5 cycles at count 10
    repeat (10) step();
    en_i = 1'b0;
    repeat (5) step();
    en_i = 1'b1;
    run_until_tick("t4_resume", 6);

    // clear on the terminal edge of a 13-cycle trimmed period
    repeat (12) step();
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    check_val("t5_tick", {31'd0, tick_o}, 32'd0);
    check_val("t5_cal", {31'd0, cal_o}, 32'd0);
    run_until_tick("t5_next", 16);

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      en_i      = ($urandom_range(0, 9) != 0);
      clr_i     = ($urandom_range(0, 199) == 0);
      fast_i    = fast_i ? ($urandom_range(0, 39) != 0) : ($urandom_range(0, 299) == 0);
      trim_ld_i = ($urandom_range(0, 49) == 0);
      trim_i    = TRIM_W'($urandom_range(0, 7));
      step();
    end

    // asynchronous reset right after a tick
    en_i = 1'b1; clr_i = 1'b0; fast_i = 1'b0; trim_ld_i = 1'b0;
    for (int i = 0; i < 64 && tick_o !== 1'b1; i++) step();
    #2 rstn_i = 1'b0;
    #1;
    check_val("t6_async_tick", {31'd0, tick_o}, 32'd0);
    check_val("t6_async_clk", {31'd0, clk_o}, 32'd0);
    check_val("t6_async_cal", {31'd0, cal_o}, 32'd0);
    model_reset();
    repeat (2) step();
    rstn_i = 1'b1;

    // trim loaded during a trimmed period waits for the next one
    trim_i = 3'b010; trim_ld_i = 1'b1;
    run_until_tick("t6_a1", 16);
    run_until_tick("t6_a2", 16);
    trim_i = 3'b110; trim_ld_i = 1'b1;
    run_until_tick("t6_a3", 18);
    run_until_tick("t6_b1", 16);
    run_until_tick("t6_b2", 16);
    run_until_tick("t6_b3", 14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
